wdt_cfg_sequencer: RTL and testbench
====================================

Name: wdt_cfg_sequencer

Overview:
- AXI write master that configures and services the watchdog slave (WDEN @0x100, WDLIVE @0x200, WTOCNT @0x300, offsets from WDT_BASE).
- Arbitrates four requesters: disable, enable, software kick and internal periodic auto-kick. Converts each request into an ordered series of single-beat AXI writes.
- Sits between the CPU-side control/status logic and the watchdog wrapper's slave port on the bus.

Parameters:
- WDT_BASE, 32'h1001_0000, base address of the watchdog slave; register offsets are added to it.
- KICK_PERIOD, 1000, auto-kick interval in cycles; 0 disables the auto-kick generator.
- MST_ID, 8'h00, constant AWID driven on every transaction.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_en  in  1  pulse: enable watchdog with timeout req_tocnt
- req_tocnt  in  32  timeout count, sampled when req_en=1
- req_dis  in  1  pulse: disable watchdog
- req_kick  in  1  pulse: software kick
- auto_kick_en  in  1  level: allow periodic auto-kick
- busy  out  1  high while any write series is in progress
- wd_on  out  1  watchdog enabled state as last programmed
- done  out  1  one-cycle pulse when a series completes
- err  out  1  one-cycle pulse when any BRESP != OKAY
- AWID_M  out  8  = MST_ID
- AWADDR_M  out  32  target register address
- AWLEN_M  out  4  = 0
- AWSIZE_M  out  3  = 3'b010
- AWBURST_M  out  2  = 2'b01 (INCR)
- AWVALID_M  out  1  write-address valid
- AWREADY_M  in  1  write-address ready
- WDATA_M  out  32  write data
- WSTRB_M  out  4  = 4'hF
- WLAST_M  out  1  = 1 whenever WVALID_M=1
- WVALID_M  out  1  write-data valid
- WREADY_M  in  1  write-data ready
- BID_M  in  8  ignored
- BRESP_M  in  2  write response
- BVALID_M  in  1  response valid
- BREADY_M  out  1  response ready

Behaviour:
- Reset is synchronous on clk. With rst=1 at an edge, all state clears and all outputs go 0 after that edge: valids, BREADY, busy, wd_on, done, err, pending flags, auto counter, tocnt latch. An in-flight transaction is abandoned.
- Pending flags p_dis, p_en, p_kick, p_auto are sticky; set by their request pulses in any state.
  - Repeat requests coalesce into one.
  - req_tocnt is latched on every req_en; the last value wins.
  - req_en and req_dis in the same cycle: p_dis is set, the enable is dropped.
  - req_kick or auto-kick arriving while wd_on=0 and p_en=0 is dropped.
- Arbitration happens in IDLE only, fixed priority p_dis > p_en > p_kick > p_auto. The selected flag clears on grant.
- Series definitions:
  - DIS: WDEN<=0.
  - EN: WTOCNT<=tocnt, then WDEN<=1.
  - KICK and AUTO: WDLIVE<=1, then WDLIVE<=0.
- Transaction FSM states: IDLE, AW, W, B.
  - IDLE: if any flag is pending, go to AW next cycle. A request pulse in cycle 0 gives AWVALID_M=1 in cycle 2 (flag registered in cycle 1, granted in cycle 1).
  - AW: AWVALID_M=1, AWADDR stable until AWREADY_M=1, then go to W.
  - W: WVALID_M=1, WDATA stable until WREADY_M=1, then go to B.
  - B: BREADY_M=1 until BVALID_M=1. Next: AW for the next write of the series, or IDLE when the series ends.
  - AW and W are never concurrent; at most one outstanding transaction.
- Series completion:
  - done pulses in the cycle after the final B handshake. busy=1 from grant until that B handshake.
  - wd_on updates at completion: DIS gives 0, EN gives 1.
  - A non-OKAY BRESP pulses err one cycle later. The series still continues, and wd_on still updates.
- Auto-kick counter (32 bit):
  - Increments while wd_on=1, auto_kick_en=1 and KICK_PERIOD!=0.
  - On reaching KICK_PERIOD-1: set p_auto and wrap to 0.
  - Held at 0 while wd_on=0 or auto_kick_en=0.
  - Cleared on completion of any KICK, AUTO or EN series.
- Requests arriving mid-series are only latched; the series always finishes before the next grant.
- AWADDR_M = WDT_BASE + offset; 32-bit wrap, no carry check.

Test Plan:
- Enable: req_en with req_tocnt=32'd500 while ready held 1 -> writes (0x1001_0300, 500) then (0x1001_0100, 1); done pulse; wd_on=1; busy low after the last B.
- Kick with stalls: wd_on=1, req_kick, AWREADY delayed 3 cycles and BVALID delayed 2 cycles -> AWADDR/WDATA held stable; writes WDLIVE=1 then WDLIVE=0; exactly one done.
- Arbitration: during an EN series, pulse req_kick twice and req_dis once -> after EN, DIS runs, then the kick is dropped (wd_on=0); exactly 2 done pulses total.
- Auto-kick: KICK_PERIOD=8, wd_on=1, auto_kick_en=1, no traffic -> a WDLIVE 1/0 series is granted every 8 counted cycles plus series length; setting auto_kick_en=0 stops it.
- Error path: BRESP=2'b10 on the WDEN write of an EN series -> err pulses one cycle after that handshake, wd_on=1, done pulses.
- Reset mid-transaction: rst=1 during state W with WVALID=1 -> at the next edge WVALID, busy and flags are 0 and wd_on=0; after release there is no activity until a new request.

Source files
------------

// File: rtl/wdt_cfg_sequencer.sv
// wdt_cfg_sequencer: arbitrates disable/enable/kick/auto-kick requests and
// issues each one as a series of single-beat AXI writes to the watchdog slave.
module wdt_cfg_sequencer #(
    parameter logic [31:0] WDT_BASE    = 32'h1001_0000,
    parameter int unsigned KICK_PERIOD = 1000,
    parameter logic [7:0]  MST_ID      = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic [31:0] req_tocnt,
    input  logic        req_dis,
    input  logic        req_kick,
    input  logic        auto_kick_en,
    output logic        busy,
    output logic        wd_on,
    output logic        done,
    output logic        err,
    output logic [7:0]  AWID_M,
    output logic [31:0] AWADDR_M,
    output logic [3:0]  AWLEN_M,
    output logic [2:0]  AWSIZE_M,
    output logic [1:0]  AWBURST_M,
    output logic        AWVALID_M,
    input  logic        AWREADY_M,
    output logic [31:0] WDATA_M,
    output logic [3:0]  WSTRB_M,
    output logic        WLAST_M,
    output logic        WVALID_M,
    input  logic        WREADY_M,
    input  logic [7:0]  BID_M,
    input  logic [1:0]  BRESP_M,
    input  logic        BVALID_M,
    output logic        BREADY_M
);
    typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;
    typedef enum logic [1:0] {K_DIS, K_EN, K_KICK, K_AUTO} kind_t;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic        step_q, step_d;
    logic        p_dis_q, p_en_q, p_kick_q, p_auto_q;
    logic        clr_dis, clr_en, clr_kick, clr_auto;
    logic        load, fin, accept, run, hit, wd_on_d;
    logic [11:0] off;
    logic [31:0] addr_q, addr_d, data_q, data_d, tocnt_q, cnt_q, cnt_d;
    logic        wd_on_q, done_q, err_q;
    logic        unused_bid;

    assign unused_bid = ^BID_M;

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        step_d   = step_q;
        load     = 1'b0;
        fin      = 1'b0;
        clr_dis  = 1'b0;
        clr_en   = 1'b0;
        clr_kick = 1'b0;
        clr_auto = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (p_dis_q) begin
                    clr_dis = 1'b1;
                    kind_d  = K_DIS;
                end else if (p_en_q) begin
                    clr_en = 1'b1;
                    kind_d = K_EN;
                end else if (p_kick_q) begin
                    clr_kick = 1'b1;
                    kind_d   = K_KICK;
                end else if (p_auto_q) begin
                    clr_auto = 1'b1;
                    kind_d   = K_AUTO;
                end
                // a kick that outlived the enable (e.g. after a disable) is discarded here
                load    = p_dis_q | p_en_q | ((p_kick_q | p_auto_q) & wd_on_q);
                state_d = load ? S_AW : S_IDLE;
                step_d  = 1'b0;
            end
            S_AW: state_d = AWREADY_M ? S_W : S_AW;
            S_W:  state_d = WREADY_M ? S_B : S_W;
            S_B: begin
                if (BVALID_M) begin
                    fin     = (kind_q == K_DIS) || step_q;
                    load    = !fin;
                    step_d  = 1'b1;
                    state_d = fin ? S_IDLE : S_AW;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        off     = kind_d == K_DIS ? 12'h100 : kind_d == K_EN ? (step_d ? 12'h100 : 12'h300) : 12'h200;
        addr_d  = load ? WDT_BASE + {20'd0, off} : addr_q;
        data_d  = !load ? data_q : kind_d == K_DIS ? 32'd0 :
                  kind_d == K_EN ? (step_d ? 32'd1 : tocnt_q) : {31'd0, ~step_d};
        accept  = wd_on_q | p_en_q | (state_q != S_IDLE && kind_q == K_EN);
        run     = wd_on_q & auto_kick_en & (KICK_PERIOD != 0);
        hit     = run & ~(fin & kind_q != K_DIS) & (cnt_q == 32'(KICK_PERIOD - 32'd1));
        cnt_d   = (!run || (fin && kind_q != K_DIS) || hit) ? 32'd0 : cnt_q + 32'd1;
        wd_on_d = !fin ? wd_on_q : kind_q == K_EN ? 1'b1 : kind_q == K_DIS ? 1'b0 : wd_on_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            kind_q   <= K_DIS;
            step_q   <= 1'b0;
            p_dis_q  <= 1'b0;
            p_en_q   <= 1'b0;
            p_kick_q <= 1'b0;
            p_auto_q <= 1'b0;
            addr_q   <= 32'd0;
            data_q   <= 32'd0;
            tocnt_q  <= 32'd0;
            cnt_q    <= 32'd0;
            wd_on_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            step_q   <= step_d;
            p_dis_q  <= (p_dis_q & ~clr_dis) | req_dis;
            p_en_q   <= (p_en_q & ~clr_en) | (req_en & ~req_dis);
            p_kick_q <= (p_kick_q & ~clr_kick) | (req_kick & accept);
            p_auto_q <= (p_auto_q & ~clr_auto) | hit;
            addr_q   <= addr_d;
            data_q   <= data_d;
            tocnt_q  <= req_en ? req_tocnt : tocnt_q;
            cnt_q    <= cnt_d;
            wd_on_q  <= wd_on_d;
            done_q   <= fin;
            err_q    <= state_q == S_B && BVALID_M && BRESP_M != 2'b00;
        end
    end

    assign busy      = state_q != S_IDLE;
    assign wd_on     = wd_on_q;
    assign done      = done_q;
    assign err       = err_q;
    assign AWID_M    = MST_ID;
    assign AWADDR_M  = addr_q;
    assign AWLEN_M   = 4'd0;
    assign AWSIZE_M  = 3'b010;
    assign AWBURST_M = 2'b01;
    assign AWVALID_M = state_q == S_AW;
    assign WDATA_M   = data_q;
    assign WSTRB_M   = 4'hF;
    assign WVALID_M  = state_q == S_W;
    assign WLAST_M   = state_q == S_W;
    assign BREADY_M  = state_q == S_B;
endmodule

// File: tb/tb_wdt_cfg_sequencer.sv
// tb_wdt_cfg_sequencer: directed bench for wdt_cfg_sequencer with a reactive
// single-beat AXI slave driven from one initial block.
module tb_wdt_cfg_sequencer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_en = 1'b0, req_dis = 1'b0, req_kick = 1'b0, auto_kick_en = 1'b0;
    logic [31:0] req_tocnt = 32'd0;
    logic        busy, wd_on, done, err;
    logic [7:0]  AWID_M;
    logic [31:0] AWADDR_M, WDATA_M;
    logic [3:0]  AWLEN_M, WSTRB_M;
    logic [2:0]  AWSIZE_M;
    logic [1:0]  AWBURST_M;
    logic        AWVALID_M, WLAST_M, WVALID_M, BREADY_M;
    logic        AWREADY_M = 1'b0, WREADY_M = 1'b0, BVALID_M = 1'b0;
    logic [7:0]  BID_M = 8'h00;
    logic [1:0]  BRESP_M = 2'b00;
    int          n_cmp = 0, n_bad = 0, done_cnt = 0, d0;

    wdt_cfg_sequencer #(.WDT_BASE(32'h1001_0000), .KICK_PERIOD(8), .MST_ID(8'h00)) dut (
        .clk(clk), .rst(rst), .req_en(req_en), .req_tocnt(req_tocnt), .req_dis(req_dis),
        .req_kick(req_kick), .auto_kick_en(auto_kick_en), .busy(busy), .wd_on(wd_on),
        .done(done), .err(err), .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M),
        .AWSIZE_M(AWSIZE_M), .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M),
        .AWREADY_M(AWREADY_M), .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M),
        .WVALID_M(WVALID_M), .WREADY_M(WREADY_M), .BID_M(BID_M), .BRESP_M(BRESP_M),
        .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // serve one write: stall AW by awd cycles, delay B by bd cycles, answer with resp
    task automatic wr(input logic [31:0] ea, input logic [31:0] ed, input int awd, input int bd,
                      input logic [1:0] resp);
        int n = 0;
        while (!AWVALID_M && n < 50) begin
            step();
            n++;
        end
        chk("aw_valid", AWVALID_M, 1);
        chk("aw_addr", AWADDR_M, ea);
        chk("aw_attr", {AWID_M, AWLEN_M, AWSIZE_M, AWBURST_M}, {8'h00, 4'd0, 3'b010, 2'b01});
        chk("aw_no_w", WVALID_M, 0);
        for (int i = 0; i < awd; i++) begin
            step();
            chk("aw_hold", {AWVALID_M, AWADDR_M}, {1'b1, ea});
        end
        AWREADY_M = 1'b1;
        step();
        AWREADY_M = 1'b0;
        chk("w_phase", {AWVALID_M, WVALID_M, WLAST_M, WSTRB_M}, {1'b0, 1'b1, 1'b1, 4'hF});
        chk("w_data", WDATA_M, ed);
        WREADY_M = 1'b1;
        step();
        WREADY_M = 1'b0;
        chk("b_ready", {WVALID_M, BREADY_M}, {1'b0, 1'b1});
        for (int i = 0; i < bd; i++) begin
            step();
            chk("b_hold", BREADY_M, 1);
        end
        BVALID_M = 1'b1;
        BRESP_M  = resp;
        step();
        BVALID_M = 1'b0;
        BRESP_M  = 2'b00;
    endtask

    initial begin
        // reset state
        repeat (3) step();
        chk("rst_out", {busy, wd_on, done, err, AWVALID_M, WVALID_M, BREADY_M}, 0);
        rst = 1'b0;
        // kick while disabled is dropped
        req_kick = 1'b1;
        step();
        req_kick = 1'b0;
        repeat (4) step();
        chk("kick_dropped", {busy, AWVALID_M}, 0);

        // enable, ready held, with first-grant latency
        req_en = 1'b1;
        req_tocnt = 32'd500;
        step();
        req_en = 1'b0;
        chk("en_lat0", AWVALID_M, 0);
        step();
        chk("en_lat1", {busy, AWVALID_M}, 2'b11);
        wr(32'h1001_0300, 32'd500, 0, 0, 2'b00);
        chk("en_mid", {done, busy}, 2'b01);
        wr(32'h1001_0100, 32'd1, 0, 0, 2'b00);
        chk("en_done", {done, busy, wd_on, err}, 4'b1010);
        step();
        chk("en_done_pulse", done, 0);

        // kick with AW and B stalls
        d0 = done_cnt;
        req_kick = 1'b1;
        step();
        req_kick = 1'b0;
        wr(32'h1001_0200, 32'd1, 3, 2, 2'b00);
        chk("kick_mid", done, 0);
        wr(32'h1001_0200, 32'd0, 0, 0, 2'b00);
        chk("kick_done", {done, wd_on}, 2'b11);
        repeat (5) step();
        chk("kick_done_cnt", done_cnt - d0, 1);

        // arbitration: kicks and disable queued during an enable
        d0 = done_cnt;
        req_en = 1'b1;
        req_tocnt = 32'd7;
        step();
        req_en = 1'b0;
        step();
        req_kick = 1'b1;
        step();
        req_kick = 1'b0;
        req_dis = 1'b1;
        step();
        req_dis = 1'b0;
        req_kick = 1'b1;
        step();
        req_kick = 1'b0;
        wr(32'h1001_0300, 32'd7, 0, 0, 2'b00);
        wr(32'h1001_0100, 32'd1, 0, 0, 2'b00);
        chk("arb_en_done", {done, wd_on}, 2'b11);
        wr(32'h1001_0100, 32'd0, 0, 0, 2'b00);
        chk("arb_dis_done", {done, wd_on}, 2'b10);
        repeat (8) step();
        chk("arb_idle", {busy, AWVALID_M}, 0);
        chk("arb_done_cnt", done_cnt - d0, 2);

        // error response on the WDEN write
        req_en = 1'b1;
        req_tocnt = 32'd9;
        step();
        req_en = 1'b0;
        wr(32'h1001_0300, 32'd9, 0, 0, 2'b00);
        chk("err_none", err, 0);
        wr(32'h1001_0100, 32'd1, 0, 0, 2'b10);
        chk("err_pulse", {err, done, wd_on}, 3'b111);
        step();
        chk("err_clear", {err, done}, 0);

        // auto-kick every 8 counted cycles
        auto_kick_en = 1'b1;
        repeat (8) step();
        chk("auto_wait", AWVALID_M, 0);
        step();
        chk("auto_grant", AWVALID_M, 1);
        wr(32'h1001_0200, 32'd1, 0, 0, 2'b00);
        wr(32'h1001_0200, 32'd0, 0, 0, 2'b00);
        chk("auto_done", done, 1);
        repeat (8) step();
        chk("auto_wait2", AWVALID_M, 0);
        step();
        chk("auto_grant2", AWVALID_M, 1);
        wr(32'h1001_0200, 32'd1, 0, 0, 2'b00);
        wr(32'h1001_0200, 32'd0, 0, 0, 2'b00);
        auto_kick_en = 1'b0;
        repeat (20) step();
        chk("auto_off", {busy, AWVALID_M}, 0);

        // reset while in W
        req_kick = 1'b1;
        step();
        req_kick = 1'b0;
        step();
        chk("rst_aw", AWVALID_M, 1);
        AWREADY_M = 1'b1;
        step();
        AWREADY_M = 1'b0;
        chk("rst_in_w", WVALID_M, 1);
        rst = 1'b1;
        step();
        chk("rst_mid", {WVALID_M, AWVALID_M, BREADY_M, busy, wd_on, done, err}, 0);
        rst = 1'b0;
        repeat (10) step();
        chk("rst_quiet", {busy, AWVALID_M, done}, 0);
        req_en = 1'b1;
        req_tocnt = 32'd3;
        step();
        req_en = 1'b0;
        wr(32'h1001_0300, 32'd3, 0, 0, 2'b00);
        wr(32'h1001_0100, 32'd1, 0, 0, 2'b00);
        chk("rst_after_en", {done, wd_on}, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
